// File: rtl/y2_pkg.sv
// Shared types and constants for the Y2 exhaustive sweep checker.
`timescale 1ns/1ps
package y2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Truth table of Y2(D,C,B,A) = sum m(4,5,6,7,11,12,13); bit i is Y at code i.
  localparam logic [15:0] Y2_TT = 16'h38F0;

  localparam int IDX_W = 4;

endpackage

// File: rtl/y2_sweep_checker_popcount16.sv
// Combinational population count of a 16-bit vector (result 0..16).
`timescale 1ns/1ps
module popcount16 (
  input  logic [15:0] i_vec,
  output logic [4:0]  o_cnt
);

  // Sum the set bits of the input vector.
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      o_cnt = o_cnt + 5'(i_vec[i]);
    end
  end

endmodule

// File: rtl/y2_sweep_checker.sv
// Drives all 16 codes into an external Y2 stage, captures the returned
// truth table and compares it against EXPECT through a start/done handshake.
`timescale 1ns/1ps
module y2_sweep_checker
  import y2_pkg::*;
#(
  parameter int          SETTLE = 1,
  parameter logic [15:0] EXPECT = Y2_TT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  input  logic        Y,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        pass,
  output logic [4:0]  mismatch
);

  // Per-code hold count reload value; SETTLE of 1 samples on the very next edge.
  localparam logic [IDX_W-1:0] CNT_INIT = IDX_W'(SETTLE - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cnt;
  logic [15:0]      r_tt;
  logic             r_pass;
  logic [4:0]       r_mm;
  logic             r_busy;
  logic             r_done;

  logic [IDX_W-1:0] w_code;
  logic [4:0]       w_mm;

  popcount16 u_popcount (
    .i_vec (r_tt ^ EXPECT),
    .o_cnt (w_mm)
  );

  // Code bus follows idx only while sweeping so the stage sees 0 otherwise.
  assign w_code = (r_state == RUN) ? r_idx : '0;
  assign A = w_code[0];
  assign B = w_code[1];
  assign C = w_code[2];
  assign D = w_code[3];

  assign busy     = r_busy;
  assign done     = r_done;
  assign tt       = r_tt;
  assign pass     = r_pass;
  assign mismatch = r_mm;

  // Sweep sequencer: step codes, sample Y after SETTLE cycles, then score.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_tt    <= '0;
      r_pass  <= 1'b0;
      r_mm    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= RUN;
            r_idx   <= '0;
            r_cnt   <= CNT_INIT;
            r_tt    <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_tt[r_idx] <= Y;
            // idx never wraps: the last code hands over to scoring instead.
            if (r_idx == 4'd15) begin
              r_state <= CHECK;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_cnt <= CNT_INIT;
            end
          end
        end
        CHECK: begin
          r_pass  <= (r_tt == EXPECT);
          r_mm    <= w_mm;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y2_sweep_checker.sv
// Self-checking bench for y2_sweep_checker with a behavioural Y2 stage
// (optionally faulted) wired to two instances: SETTLE=1 and SETTLE=3.
`timescale 1ns/1ps
module tb_y2_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start1, start3;
  logic [1:0]  fault;  // 0 good, 1 stuck-0, 2 stuck-1, 3 code 11 inverted

  logic        A1, B1, C1, D1, Y1, busy1, done1, pass1;
  logic [15:0] tt1;
  logic [4:0]  mm1;
  logic        A3, B3, C3, D3, Y3, busy3, done3, pass3;
  logic [15:0] tt3;
  logic [4:0]  mm3;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] tt;
    logic        pass;
    logic [4:0]  mm;
    int          lat;
  } exp_t;

  exp_t sb[$];

  // observations filled in by sweep()
  int          o_lat;
  bit          o_steps_ok;
  bit          o_width1;
  logic [15:0] o_tt;
  logic        o_pass;
  logic [4:0]  o_mm;

  function automatic logic model_y(logic [1:0] f, logic [3:0] code);
    logic y;
    case (code)
      4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd12, 4'd13: y = 1'b1;
      default: y = 1'b0;
    endcase
    case (f)
      2'd1: return 1'b0;
      2'd2: return 1'b1;
      2'd3: return (code == 4'd11) ? ~y : y;
      default: return y;
    endcase
  endfunction

  function automatic exp_t predict(logic [1:0] f, int n);
    exp_t e;
    logic [15:0] diff;
    e.tt = '0;
    for (int i = 0; i < 16; i++) e.tt[i] = model_y(f, 4'(i));
    diff = e.tt ^ 16'h38F0;
    e.mm = '0;
    for (int i = 0; i < 16; i++) if (diff[i]) e.mm = e.mm + 5'd1;
    e.pass = (e.tt == 16'h38F0);
    e.lat  = 16 * n + 1;
    return e;
  endfunction

  always_comb Y1 = model_y(fault, {D1, C1, B1, A1});
  always_comb Y3 = model_y(fault, {D3, C3, B3, A3});

  y2_sweep_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .A(A1), .B(B1), .C(C1), .D(D1), .Y(Y1),
    .busy(busy1), .done(done1), .tt(tt1), .pass(pass1), .mismatch(mm1)
  );

  y2_sweep_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .A(A3), .B(B3), .C(C3), .D(D3), .Y(Y3),
    .busy(busy3), .done(done3), .tt(tt3), .pass(pass3), .mismatch(mm3)
  );

  // Runs one sweep on the selected instance (called #1 after an edge, DUT idle),
  // pushes the prediction and records what the DUT produced.
  task automatic sweep(input int n, input logic [1:0] f);
    int c;
    logic [3:0] code;
    logic dn;
    fault = f;
    sb.push_back(predict(f, n));
    if (n == 3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    c = 0;
    o_steps_ok = 1'b1;
    while (1) begin
      code = (n == 3) ? {D3, C3, B3, A3} : {D1, C1, B1, A1};
      dn   = (n == 3) ? done3 : done1;
      if (dn || c >= 200) break;
      if (c < 16 * n && code != 4'(c / n)) o_steps_ok = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    o_lat  = dn ? c : -1;
    o_tt   = (n == 3) ? tt3 : tt1;
    o_pass = (n == 3) ? pass3 : pass1;
    o_mm   = (n == 3) ? mm3 : mm1;
    @(posedge clk); #1;
    o_width1 = (n == 3) ? !done3 : !done1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; fault = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++; if ({D1, C1, B1, A1, busy1, done1} !== 6'b0) begin miscompares++; $display("FAIL reset_ctl1: got %b want 000000", {D1, C1, B1, A1, busy1, done1}); end
    vectors++; if ({tt1, pass1, mm1} !== 22'h0) begin miscompares++; $display("FAIL reset_res1: got tt=%h pass=%b mm=%0d want 0", tt1, pass1, mm1); end
    vectors++; if ({D3, C3, B3, A3, busy3, done3, tt3, pass3, mm3} !== 28'h0) begin miscompares++; $display("FAIL reset_dut3: got tt=%h busy=%b want 0", tt3, busy3); end
  endtask

  task automatic test_nominal();
    exp_t e;
    sweep(1, 2'd0);
    e = sb.pop_front();
    vectors++; if (o_lat !== e.lat) begin miscompares++; $display("FAIL nom_latency: got %0d want %0d", o_lat, e.lat); end
    vectors++; if (o_width1 !== 1'b1) begin miscompares++; $display("FAIL nom_done_width: got %b want 1", o_width1); end
    vectors++; if (o_steps_ok !== 1'b1) begin miscompares++; $display("FAIL nom_code_steps: got %b want 1", o_steps_ok); end
    vectors++; if (o_tt !== e.tt) begin miscompares++; $display("FAIL nom_tt: got %h want %h", o_tt, e.tt); end
    vectors++; if (o_pass !== e.pass) begin miscompares++; $display("FAIL nom_pass: got %b want %b", o_pass, e.pass); end
    vectors++; if (o_mm !== e.mm) begin miscompares++; $display("FAIL nom_mismatch: got %0d want %0d", o_mm, e.mm); end
  endtask

  task automatic test_stuck();
    exp_t e;
    for (int s = 1; s <= 2; s++) begin
      sweep(1, 2'(s));
      e = sb.pop_front();
      vectors++; if (o_tt !== e.tt) begin miscompares++; $display("FAIL stuck%0d_tt: got %h want %h", s - 1, o_tt, e.tt); end
      vectors++; if (o_pass !== e.pass) begin miscompares++; $display("FAIL stuck%0d_pass: got %b want %b", s - 1, o_pass, e.pass); end
      vectors++; if (o_mm !== e.mm) begin miscompares++; $display("FAIL stuck%0d_mismatch: got %0d want %0d", s - 1, o_mm, e.mm); end
    end
  endtask

  task automatic test_settle3();
    exp_t e;
    sweep(3, 2'd0);
    e = sb.pop_front();
    vectors++; if (o_lat !== e.lat) begin miscompares++; $display("FAIL s3_latency: got %0d want %0d", o_lat, e.lat); end
    vectors++; if (o_steps_ok !== 1'b1) begin miscompares++; $display("FAIL s3_code_hold: got %b want 1", o_steps_ok); end
    vectors++; if (o_tt !== e.tt) begin miscompares++; $display("FAIL s3_tt: got %h want %h", o_tt, e.tt); end
    vectors++; if (o_pass !== e.pass) begin miscompares++; $display("FAIL s3_pass: got %b want %b", o_pass, e.pass); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int c;
    int ndone;
    fault = 2'd0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    c = 0;
    while ({D1, C1, B1, A1} != 4'd5 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    vectors++; if ({D1, C1, B1, A1} !== 4'd5) begin miscompares++; $display("FAIL rmid_reach5: got %0d want 5", {D1, C1, B1, A1}); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if ({D1, C1, B1, A1, busy1, done1} !== 6'b0) begin miscompares++; $display("FAIL rmid_ctl: got %b want 000000", {D1, C1, B1, A1, busy1, done1}); end
    vectors++; if ({tt1, pass1, mm1} !== 22'h0) begin miscompares++; $display("FAIL rmid_res: got tt=%h pass=%b mm=%0d want 0", tt1, pass1, mm1); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1 || busy1) ndone++;
      @(posedge clk); #1;
    end
    vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL rmid_no_done: got %0d active cycles want 0", ndone); end
    sweep(1, 2'd0);
    e = sb.pop_front();
    vectors++; if (o_lat !== e.lat) begin miscompares++; $display("FAIL rmid_latency: got %0d want %0d", o_lat, e.lat); end
    vectors++; if (o_tt !== e.tt) begin miscompares++; $display("FAIL rmid_tt: got %h want %h", o_tt, e.tt); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int c;
    fault = 2'd0;
    start1 = 1'b1;
    c = 0;
    while (!done1 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    vectors++; if (done1 !== 1'b1) begin miscompares++; $display("FAIL b2b_first_done: got %b want 1", done1); end
    for (int s = 0; s < 3; s++) begin
      sb.push_back(predict(2'd0, 1));
      c = 0;
      while (1) begin
        @(posedge clk); #1;
        c++;
        if (c == 5) start1 = 1'b0;
        if (c == 6) start1 = 1'b1;
        if (done1 || c >= 60) break;
      end
      e = sb.pop_front();
      vectors++; if (c !== 19) begin miscompares++; $display("FAIL b2b_period%0d: got %0d want 19", s, c); end
      vectors++; if (tt1 !== e.tt) begin miscompares++; $display("FAIL b2b_tt%0d: got %h want %h", s, tt1, e.tt); end
    end
    start1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_bit11_hold();
    exp_t e;
    int c;
    sweep(1, 2'd3);
    e = sb.pop_front();
    vectors++; if (o_tt !== e.tt) begin miscompares++; $display("FAIL b11_tt: got %h want %h", o_tt, e.tt); end
    vectors++; if (o_pass !== e.pass) begin miscompares++; $display("FAIL b11_pass: got %b want %b", o_pass, e.pass); end
    vectors++; if (o_mm !== e.mm) begin miscompares++; $display("FAIL b11_mismatch: got %0d want %0d", o_mm, e.mm); end
    repeat (5) @(posedge clk);
    #1;
    vectors++; if ({tt1, pass1, mm1} !== {e.tt, e.pass, e.mm}) begin miscompares++; $display("FAIL b11_hold: got tt=%h pass=%b mm=%0d want tt=%h pass=%b mm=%0d", tt1, pass1, mm1, e.tt, e.pass, e.mm); end
    fault = 2'd0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    vectors++; if (tt1 !== 16'h0000) begin miscompares++; $display("FAIL b11_tt_clear: got %h want 0000", tt1); end
    vectors++; if ({pass1, mm1} !== {e.pass, e.mm}) begin miscompares++; $display("FAIL b11_old_result: got pass=%b mm=%0d want pass=%b mm=%0d", pass1, mm1, e.pass, e.mm); end
    e = predict(2'd0, 1);
    c = 0;
    while (!done1 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    vectors++; if ({tt1, pass1, mm1} !== {e.tt, e.pass, e.mm}) begin miscompares++; $display("FAIL b11_rerun: got tt=%h pass=%b mm=%0d want tt=%h pass=%b mm=%0d", tt1, pass1, mm1, e.tt, e.pass, e.mm); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stuck();
    test_settle3();
    test_reset_mid();
    test_back_to_back();
    test_bit11_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
